// File: rtl/nvme_sq_doorbell_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nvme_sq_doorbell_arb_if : AXI-Lite doorbell write channel toward NVMe BAR   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface nvme_sq_doorbell_arb_if #(
  parameter int NL_ADDR_WIDTH = 32,
  parameter int NL_DATA_WIDTH = 32
);
  logic [NL_ADDR_WIDTH-1:0]   nl_awaddr;
  logic                       nl_awvalid;
  logic                       nl_awready;
  logic [NL_DATA_WIDTH-1:0]   nl_wdata;
  logic [NL_DATA_WIDTH/8-1:0] nl_wstrb;
  logic                       nl_wvalid;
  logic                       nl_wready;
  logic [1:0]                 nl_bresp;
  logic                       nl_bvalid;
  logic                       nl_bready;

  modport master (
    output nl_awaddr, nl_awvalid, nl_wdata, nl_wstrb, nl_wvalid, nl_bready,
    input  nl_awready, nl_wready, nl_bresp, nl_bvalid
  );

  modport slave (
    input  nl_awaddr, nl_awvalid, nl_wdata, nl_wstrb, nl_wvalid, nl_bready,
    output nl_awready, nl_wready, nl_bresp, nl_bvalid
  );
endinterface
`default_nettype wire

// File: rtl/nvme_sq_doorbell_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nvme_sq_doorbell_arb : coalescing multi-queue SQ tail doorbell, RR arbiter  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module nvme_sq_doorbell_arb #(
  parameter int                       NUM_Q         = 4,
  parameter int                       QID_WIDTH     = 2,
  parameter int                       SQ_ADDR_WIDTH = 9,
  parameter int                       NL_ADDR_WIDTH = 32,
  parameter int                       NL_DATA_WIDTH = 32,
  parameter logic [NL_ADDR_WIDTH-1:0] DB_BASE       = 32'h0000_1000,
  parameter int                       DSTRD         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     upd_valid_i,
  input  logic [QID_WIDTH-1:0]     upd_qid_i,
  input  logic [SQ_ADDR_WIDTH-1:0] upd_tail_i,
  nvme_sq_doorbell_arb_if.master   nl,
  output logic [NUM_Q-1:0]         pending_o,
  output logic                     busy_o,
  output logic [15:0]              err_cnt_o,
  output logic [QID_WIDTH-1:0]     err_qid_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q;
  logic [QID_WIDTH-1:0]     rr_ptr_q;
  logic [NUM_Q-1:0]         pending_q;
  logic [NUM_Q-1:0]         pending_d;
  logic [SQ_ADDR_WIDTH-1:0] tail_q [NUM_Q];
  logic [QID_WIDTH-1:0]     gnt_qid_q;
  logic [NL_ADDR_WIDTH-1:0] awaddr_q;
  logic [NL_DATA_WIDTH-1:0] wdata_q;
  logic                     awvalid_q;
  logic                     wvalid_q;
  logic                     bready_q;
  logic                     busy_q;
  logic [15:0]              err_cnt_q;
  logic [QID_WIDTH-1:0]     err_qid_q;

  int                       w_idx;
  logic                     w_found;
  logic                     w_grant;
  logic [QID_WIDTH-1:0]     w_gnt_qid;
  logic [QID_WIDTH-1:0]     w_rr_next;
  logic [SQ_ADDR_WIDTH-1:0] w_gnt_tail;
  logic [NL_ADDR_WIDTH-1:0] w_awaddr;

  // Wrap-around search for the first pending queue at or after rr_ptr.
  always_comb begin
    w_idx      = 0;
    w_found    = 1'b0;
    w_gnt_qid  = '0;
    w_gnt_tail = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      w_idx = int'(rr_ptr_q) + k;
      if (w_idx >= NUM_Q) begin
        w_idx = w_idx - NUM_Q;
      end
      if (!w_found && pending_q[QID_WIDTH'(w_idx)]) begin
        w_found   = 1'b1;
        w_gnt_qid = QID_WIDTH'(w_idx);
      end
    end
    for (int i = 0; i < NUM_Q; i++) begin
      if (w_gnt_qid == QID_WIDTH'(i)) begin
        w_gnt_tail = tail_q[i];
      end
    end
    w_grant   = (state_q == IDLE) && en_i && w_found;
    w_rr_next = (w_gnt_qid == QID_WIDTH'(NUM_Q - 1)) ? '0 : w_gnt_qid + 1'b1;
    w_awaddr  = DB_BASE + (NL_ADDR_WIDTH'(w_gnt_qid) << (DSTRD + 3));
  end

  // A fresh update to the granted queue re-arms it even in the grant cycle.
  always_comb begin
    pending_d = pending_q;
    if (w_grant) begin
      pending_d[w_gnt_qid] = 1'b0;
    end
    for (int i = 0; i < NUM_Q; i++) begin
      if (upd_valid_i && (upd_qid_i == QID_WIDTH'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_Q; i++) begin
        tail_q[i] <= '0;
      end
      gnt_qid_q <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
      err_qid_q <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_Q; i++) begin
        if (upd_valid_i && (upd_qid_i == QID_WIDTH'(i))) begin
          tail_q[i] <= upd_tail_i;
        end
      end
      case (state_q)
        IDLE: begin
          if (w_grant) begin
            state_q   <= XFER;
            gnt_qid_q <= w_gnt_qid;
            rr_ptr_q  <= w_rr_next;
            awaddr_q  <= w_awaddr;
            wdata_q   <= NL_DATA_WIDTH'(w_gnt_tail);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        XFER: begin
          if (nl.nl_awready) begin
            awvalid_q <= 1'b0;
          end
          if (nl.nl_wready) begin
            wvalid_q <= 1'b0;
          end
          if ((!awvalid_q || nl.nl_awready) && (!wvalid_q || nl.nl_wready)) begin
            state_q  <= RESP;
            bready_q <= 1'b1;
          end
        end
        RESP: begin
          if (nl.nl_bvalid) begin
            state_q  <= IDLE;
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            if (nl.nl_bresp != 2'b00) begin
              err_qid_q <= gnt_qid_q;
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nl.nl_awaddr  = awaddr_q;
  assign nl.nl_awvalid = awvalid_q;
  assign nl.nl_wdata   = wdata_q;
  assign nl.nl_wstrb   = '1;
  assign nl.nl_wvalid  = wvalid_q;
  assign nl.nl_bready  = bready_q;
  assign pending_o     = pending_q;
  assign busy_o        = busy_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_qid_o     = err_qid_q;

endmodule
`default_nettype wire

// File: tb/tb_nvme_sq_doorbell_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_nvme_sq_doorbell_arb : directed scenarios plus random traffic vs model   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_nvme_sq_doorbell_arb;
  localparam int          NUM_Q   = 4;
  localparam int          DSTRD   = 0;
  localparam logic [31:0] DB_BASE = 32'h0000_1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic       upd_valid_i = 1'b0;
  logic [1:0] upd_qid_i = '0;
  logic [8:0] upd_tail_i = '0;
  logic [3:0] pending_o;
  logic       busy_o;
  logic [15:0] err_cnt_o;
  logic [1:0] err_qid_o;

  logic       s_awready = 1'b0;
  logic       s_wready = 1'b0;
  logic       s_bvalid = 1'b0;
  logic [1:0] s_bresp = 2'b00;

  nvme_sq_doorbell_arb_if #(.NL_ADDR_WIDTH(32), .NL_DATA_WIDTH(32)) nl ();
  assign nl.nl_awready = s_awready;
  assign nl.nl_wready  = s_wready;
  assign nl.nl_bvalid  = s_bvalid;
  assign nl.nl_bresp   = s_bresp;

  nvme_sq_doorbell_arb #(
    .NUM_Q(4), .QID_WIDTH(2), .SQ_ADDR_WIDTH(9), .NL_ADDR_WIDTH(32),
    .NL_DATA_WIDTH(32), .DB_BASE(32'h0000_1000), .DSTRD(0)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .upd_valid_i(upd_valid_i),
    .upd_qid_i(upd_qid_i), .upd_tail_i(upd_tail_i), .nl(nl.master),
    .pending_o(pending_o), .busy_o(busy_o), .err_cnt_o(err_cnt_o), .err_qid_o(err_qid_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: which queue is in flight, which channels remain.
  bit          m_pend [NUM_Q];
  int          m_tail [NUM_Q];
  int          m_rr, m_inflight, m_errcnt, m_errq, m_q;
  bit          m_aw, m_w, m_wb;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_pvec;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr = 0; m_inflight = -1; m_errcnt = 0; m_errq = 0;
      m_aw = 0; m_w = 0; m_wb = 0; m_addr = '0; m_data = '0;
      for (int i = 0; i < NUM_Q; i++) begin
        m_pend[i] = 0;
        m_tail[i] = 0;
      end
    end else begin
      if (m_inflight < 0) begin
        m_q = -1;
        for (int k = 0; k < NUM_Q; k++) begin
          if (m_q < 0 && m_pend[(m_rr + k) % NUM_Q]) m_q = (m_rr + k) % NUM_Q;
        end
        if (en_i && m_q >= 0) begin
          m_inflight = m_q;
          m_pend[m_q] = 0;
          m_rr = (m_q + 1) % NUM_Q;
          m_addr = DB_BASE + 32'(2 * m_q * (4 << DSTRD));
          m_data = 32'(m_tail[m_q]);
          m_aw = 1;
          m_w = 1;
        end
      end else if (m_aw || m_w) begin
        if (s_awready) m_aw = 0;
        if (s_wready) m_w = 0;
        if (!m_aw && !m_w) m_wb = 1;
      end else if (m_wb && s_bvalid) begin
        m_wb = 0;
        if (s_bresp != 2'b00) begin
          if (m_errcnt < 65535) m_errcnt++;
          m_errq = m_inflight;
        end
        m_inflight = -1;
      end
      if (upd_valid_i && int'(upd_qid_i) < NUM_Q) begin
        m_tail[upd_qid_i] = int'(upd_tail_i);
        m_pend[upd_qid_i] = 1;
      end
    end
  end

  logic [31:0] aw_log [$];
  logic [31:0] w_log [$];

  always @(negedge clk) begin
    for (int i = 0; i < NUM_Q; i++) m_pvec[i] = m_pend[i];
    chk("pending", 32'(pending_o), 32'(m_pvec));
    chk("awvalid", 32'(nl.nl_awvalid), 32'(m_aw));
    chk("wvalid", 32'(nl.nl_wvalid), 32'(m_w));
    chk("bready", 32'(nl.nl_bready), 32'(m_wb));
    chk("busy", 32'(busy_o), 32'(m_inflight >= 0));
    chk("err_cnt", 32'(err_cnt_o), 32'(m_errcnt));
    chk("err_qid", 32'(err_qid_o), 32'(m_errq));
    chk("wstrb", 32'(nl.nl_wstrb), 32'h0000_000F);
    if (m_aw) chk("awaddr", nl.nl_awaddr, m_addr);
    if (m_w) chk("wdata", nl.nl_wdata, m_data);
    if (nl.nl_awvalid && s_awready) aw_log.push_back(nl.nl_awaddr);
    if (nl.nl_wvalid && s_wready) w_log.push_back(nl.nl_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en_i = 1'b0; upd_valid_i = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic post(input int q, input int t);
    upd_valid_i = 1'b1;
    upd_qid_i = 2'(q);
    upd_tail_i = 9'(t);
  endtask

  function automatic logic [31:0] log_at(input int which, input int idx);
    if (which == 0) return (aw_log.size() > idx) ? aw_log[idx] : 32'hDEAD_BEEF;
    return (w_log.size() > idx) ? w_log[idx] : 32'hDEAD_BEEF;
  endfunction

  int          seen;
  logic [31:0] rr_exp [5] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h1000};

  initial begin
    do_reset();
    chk("rst_pending", 32'(pending_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_awaddr", nl.nl_awaddr, 32'h0);
    chk("rst_wdata", nl.nl_wdata, 32'h0);

    // single update with an always-ready slave
    en_i = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    post(1, 5);
    tick(); upd_valid_i = 1'b0;
    chk("single_pend_t1", 32'(pending_o), 32'h2);
    tick();
    chk("single_awvalid", 32'(nl.nl_awvalid), 32'h1);
    chk("single_awaddr", nl.nl_awaddr, 32'h1008);
    chk("single_wdata", nl.nl_wdata, 32'h5);
    chk("single_pend_t2", 32'(pending_o), 32'h0);
    tick();
    chk("single_bready", 32'(nl.nl_bready), 32'h1);
    tick();
    chk("single_busy_end", 32'(busy_o), 32'h0);

    // coalescing while disabled
    en_i = 1'b0;
    post(2, 3); tick();
    post(2, 7); tick();
    post(2, 9'hFF); tick();
    upd_valid_i = 1'b0;
    aw_log.delete(); w_log.delete();
    en_i = 1'b1;
    repeat (8) tick();
    chk("coal_count", 32'(aw_log.size()), 32'd1);
    chk("coal_awaddr", log_at(0, 0), 32'h1010);
    chk("coal_wdata", log_at(1, 0), 32'h0FF);

    // round-robin with q0 continuously re-posted
    do_reset();
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    for (int q = 0; q < NUM_Q; q++) begin
      post(q, 16 + q);
      tick();
    end
    post(0, 9'h20);
    aw_log.delete(); w_log.delete();
    en_i = 1'b1;
    repeat (16) tick();
    upd_valid_i = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), log_at(0, i), rr_exp[i]);

    // update to the queue whose write is stalled in XFER
    do_reset();
    s_wready = 1'b1; s_bvalid = 1'b1; en_i = 1'b1;
    aw_log.delete(); w_log.delete();
    post(3, 4);
    tick(); upd_valid_i = 1'b0;
    tick();
    post(3, 10);
    tick(); upd_valid_i = 1'b0;
    repeat (4) tick();
    s_awready = 1'b1;
    repeat (10) tick();
    chk("flight_nwrites", 32'(w_log.size()), 32'd2);
    chk("flight_w0", log_at(1, 0), 32'd4);
    chk("flight_w1", log_at(1, 1), 32'd10);
    chk("flight_aw1", log_at(0, 1), 32'h1018);

    // W completes three cycles before AW; SLVERR response
    do_reset();
    s_bresp = 2'b10; en_i = 1'b1;
    post(2, 9'h33);
    tick(); upd_valid_i = 1'b0;
    tick();
    chk("split_aw_c2", 32'(nl.nl_awvalid), 32'h1);
    chk("split_w_c2", 32'(nl.nl_wvalid), 32'h1);
    s_wready = 1'b1;
    tick(); s_wready = 1'b0;
    chk("split_w_c3", 32'(nl.nl_wvalid), 32'h0);
    chk("split_aw_c3", 32'(nl.nl_awvalid), 32'h1);
    tick();
    chk("split_aw_c4", 32'(nl.nl_awvalid), 32'h1);
    tick(); s_awready = 1'b1;
    tick(); s_awready = 1'b0;
    chk("split_aw_done", 32'(nl.nl_awvalid), 32'h0);
    chk("split_bready", 32'(nl.nl_bready), 32'h1);
    s_bvalid = 1'b1;
    tick(); s_bvalid = 1'b0; s_bresp = 2'b00;
    chk("err_cnt_lit", 32'(err_cnt_o), 32'd1);
    chk("err_qid_lit", 32'(err_qid_o), 32'd2);
    chk("err_busy", 32'(busy_o), 32'h0);

    // asynchronous reset in the middle of XFER
    en_i = 1'b1;
    post(1, 7);
    tick(); upd_valid_i = 1'b0;
    tick();
    chk("rstmid_aw_before", 32'(nl.nl_awvalid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_aw", 32'(nl.nl_awvalid), 32'h0);
    chk("rstmid_w", 32'(nl.nl_wvalid), 32'h0);
    chk("rstmid_pending", 32'(pending_o), 32'h0);
    tick(); rst = 1'b0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (nl.nl_awvalid) seen++;
    end
    chk("rstmid_no_write", 32'(seen), 32'd0);

    // random traffic, checked every cycle by the model
    do_reset();
    repeat (4000) begin
      en_i        = ($urandom_range(0, 9) != 0);
      upd_valid_i = ($urandom_range(0, 2) == 0);
      upd_qid_i   = 2'($urandom_range(0, 3));
      upd_tail_i  = 9'($urandom);
      s_awready   = 1'($urandom_range(0, 1));
      s_wready    = 1'($urandom_range(0, 1));
      s_bvalid    = 1'($urandom_range(0, 1));
      s_bresp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end
    upd_valid_i = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
